// File: rtl/fifo_v3_pkg.sv
// rtl/fifo_v3_pkg.sv - shared sizing helper for the fifo_v3 slice
package fifo_v3_pkg;

    function automatic int addr_depth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_v3_if.sv
// rtl/fifo_v3_if.sv - fifo_v3 data/handshake/status bundle
interface fifo_v3_if import fifo_v3_pkg::*; #(
    parameter int  DEPTH = 8,
    parameter type dtype = logic [31:0]
) ();
    localparam int ADDR_DEPTH = addr_depth(DEPTH);

    logic                  flush_i;
    logic                  testmode_i;
    logic                  full_o;
    logic                  empty_o;
    logic [ADDR_DEPTH-1:0] usage_o;
    dtype                  data_i;
    logic                  push_i;
    dtype                  data_o;
    logic                  pop_i;

    modport slave (
        input  flush_i, testmode_i, data_i, push_i, pop_i,
        output full_o, empty_o, usage_o, data_o
    );

    modport master (
        output flush_i, testmode_i, data_i, push_i, pop_i,
        input  full_o, empty_o, usage_o, data_o
    );
endinterface

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - in-order FIFO with optional fall-through and zero-depth pass-through
// Optional simulation assertions are enabled by defining FIFO_V3_ASSERT_EN.
module fifo_v3 import fifo_v3_pkg::*; #(
    parameter bit  FALL_THROUGH = 1'b0,
    parameter int  DATA_WIDTH   = 32,
    parameter int  DEPTH        = 8,
    parameter type dtype        = logic [DATA_WIDTH-1:0]
) (
    input  logic     clk_i,
    input  logic     rst_i,
    fifo_v3_if.slave bus
);
    localparam int ADDR_DEPTH = addr_depth(DEPTH);

    logic unused_testmode;
    assign unused_testmode = bus.testmode_i;

`ifdef FIFO_V3_ASSERT_EN
    if (DEPTH < 0 || $bits(dtype) == 0) begin : g_bad_cfg
        $fatal(1, "fifo_v3: DEPTH must be >= 0 and dtype must be non-empty");
    end
`else
`endif

    if (DEPTH == 0) begin : g_pass
        logic unused_pass;
        assign unused_pass  = ^{clk_i, rst_i, bus.flush_i};
        assign bus.data_o   = bus.data_i;
        assign bus.empty_o  = ~bus.push_i;
        assign bus.full_o   = ~bus.pop_i;
        assign bus.usage_o  = '0;
    end else begin : g_fifo
        localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH+1)'(DEPTH);
        localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);

        dtype                  mem_q [DEPTH];
        logic [ADDR_DEPTH-1:0] read_ptr_q, read_ptr_d;
        logic [ADDR_DEPTH-1:0] write_ptr_q, write_ptr_d;
        logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_d;
        logic                  mem_we;
        logic                  full;
        logic                  empty;
        logic                  ft_active;
        logic                  do_push;
        logic                  do_pop;
        dtype                  data_out;

        // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1.
        function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
            return (p == LAST_PTR) ? '0 : p + 1'b1;
        endfunction

        always_comb begin
            read_ptr_d   = read_ptr_q;
            write_ptr_d  = write_ptr_q;
            status_cnt_d = status_cnt_q;
            mem_we       = 1'b0;

            full      = (status_cnt_q == FULL_CNT);
            ft_active = FALL_THROUGH && (status_cnt_q == '0) && bus.push_i;
            empty     = (status_cnt_q == '0) && !ft_active;
            data_out  = ft_active ? bus.data_i : mem_q[read_ptr_q];

            // A bypassed push+pop on an empty fall-through FIFO touches no state.
            do_pop  = bus.pop_i && !empty && !ft_active;
            do_push = bus.push_i && (!full || do_pop) && !(ft_active && bus.pop_i);

            if (do_push) begin
                mem_we      = 1'b1;
                write_ptr_d = ptr_inc(write_ptr_q);
            end
            if (do_pop) begin
                read_ptr_d = ptr_inc(read_ptr_q);
            end
            if (do_push && !do_pop) begin
                status_cnt_d = status_cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                status_cnt_d = status_cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                read_ptr_q   <= '0;
                write_ptr_q  <= '0;
                status_cnt_q <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (bus.flush_i) begin
                read_ptr_q   <= '0;
                write_ptr_q  <= '0;
                status_cnt_q <= '0;
            end else begin
                read_ptr_q   <= read_ptr_d;
                write_ptr_q  <= write_ptr_d;
                status_cnt_q <= status_cnt_d;
                if (mem_we) begin
                    mem_q[write_ptr_q] <= bus.data_i;
                end
            end
        end

        assign bus.full_o  = full;
        assign bus.empty_o = empty;
        assign bus.usage_o = status_cnt_q[ADDR_DEPTH-1:0];
        assign bus.data_o  = data_out;

`ifdef FIFO_V3_ASSERT_EN
        push_while_full: assert property (@(posedge clk_i) disable iff (rst_i)
            !(bus.push_i && full && !bus.pop_i))
            else $error("fifo_v3: push while full");
        pop_while_empty: assert property (@(posedge clk_i) disable iff (rst_i)
            !(bus.pop_i && empty))
            else $error("fifo_v3: pop while empty");
`else
`endif
    end
endmodule

// File: tb/tb_fifo_v3.sv
// tb/tb_fifo_v3.sv - directed and randomized checks of fifo_v3 in four configurations
module tb_fifo_v3;
    logic clk;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    fifo_v3_if #(.DEPTH(4), .dtype(logic [7:0])) b4 ();
    fifo_v3_if #(.DEPTH(3), .dtype(logic [7:0])) b3 ();
    fifo_v3_if #(.DEPTH(2), .dtype(logic [7:0])) b2 ();
    fifo_v3_if #(.DEPTH(0), .dtype(logic [7:0])) b0 ();

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u4 (.clk_i(clk), .rst_i(rst), .bus(b4));
    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u3 (.clk_i(clk), .rst_i(rst), .bus(b3));
    fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(2)) u2 (.clk_i(clk), .rst_i(rst), .bus(b2));
    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(0)) u0 (.clk_i(clk), .rst_i(rst), .bus(b0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q3[$];
    logic [7:0] q2[$];

    initial begin
        logic ft2, dp, dpu;
        {b4.flush_i, b4.testmode_i, b4.push_i, b4.pop_i, b4.data_i} = '0;
        {b3.flush_i, b3.testmode_i, b3.push_i, b3.pop_i, b3.data_i} = '0;
        {b2.flush_i, b2.testmode_i, b2.push_i, b2.pop_i, b2.data_i} = '0;
        {b0.flush_i, b0.testmode_i, b0.push_i, b0.pop_i, b0.data_i} = '0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_empty", 32'(b4.empty_o), 1);
        chk("rst_full",  32'(b4.full_o),  0);
        chk("rst_usage", 32'(b4.usage_o), 0);
        chk("rst_data",  32'(b4.data_o),  0);

        // Fill and drain DEPTH=4
        b4.push_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b4.data_i = 8'(8'hA + i);
            cyc();
        end
        chk("fill_full", 32'(b4.full_o), 1);
        b4.data_i = 8'hE;
        cyc();
        b4.push_i = 1'b0;
        #1;
        chk("over_full",  32'(b4.full_o),  1);
        chk("over_usage", 32'(b4.usage_o), 0);
        b4.pop_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(b4.data_o), 32'(8'hA + i));
            cyc();
        end
        chk("drain_empty", 32'(b4.empty_o), 1);
        cyc();
        chk("underflow_usage", 32'(b4.usage_o), 0);
        chk("underflow_empty", 32'(b4.empty_o), 1);
        b4.pop_i = 1'b0;

        // Full push+pop with wrap, DEPTH=3
        b3.push_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            b3.data_i = 8'(i);
            cyc();
        end
        b3.data_i = 8'd4;
        b3.pop_i  = 1'b1;
        #1;
        chk("wrap_head", 32'(b3.data_o), 1);
        chk("wrap_full_before", 32'(b3.full_o), 1);
        cyc();
        b3.push_i = 1'b0;
        #1;
        chk("wrap_full_after", 32'(b3.full_o), 1);
        chk("wrap_usage", 32'(b3.usage_o), 3);
        for (int i = 2; i <= 4; i++) begin
            chk("wrap_data", 32'(b3.data_o), 32'(i));
            cyc();
        end
        b3.pop_i = 1'b0;
        #1;
        chk("wrap_empty", 32'(b3.empty_o), 1);

        // Fall-through DEPTH=2
        b2.push_i = 1'b1;
        b2.pop_i  = 1'b1;
        b2.data_i = 8'h5;
        #1;
        chk("ft_data",  32'(b2.data_o),  5);
        chk("ft_empty", 32'(b2.empty_o), 0);
        cyc();
        b2.push_i = 1'b0;
        b2.pop_i  = 1'b0;
        #1;
        chk("ft_after_empty", 32'(b2.empty_o), 1);
        chk("ft_after_usage", 32'(b2.usage_o), 0);
        b2.push_i = 1'b1;
        b2.data_i = 8'h7;
        #1;
        chk("ft_store_data", 32'(b2.data_o), 7);
        cyc();
        b2.push_i = 1'b0;
        #1;
        chk("ft_store_usage", 32'(b2.usage_o), 1);
        chk("ft_store_head",  32'(b2.data_o),  7);
        b2.pop_i = 1'b1;
        cyc();
        b2.pop_i = 1'b0;
        #1;
        chk("ft_store_empty", 32'(b2.empty_o), 1);

        // Flush beats push
        b4.push_i = 1'b1;
        b4.data_i = 8'h11;
        cyc();
        b4.data_i = 8'h22;
        cyc();
        b4.flush_i = 1'b1;
        b4.data_i  = 8'h33;
        cyc();
        b4.flush_i = 1'b0;
        b4.push_i  = 1'b0;
        #1;
        chk("flush_empty", 32'(b4.empty_o), 1);
        chk("flush_usage", 32'(b4.usage_o), 0);

        // Reset mid-operation
        b4.push_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b4.data_i = 8'(8'h40 + i);
            cyc();
        end
        b4.push_i = 1'b0;
        #1;
        chk("pre_rst_usage", 32'(b4.usage_o), 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(b4.empty_o), 1);
        chk("mid_rst_full",  32'(b4.full_o),  0);
        chk("mid_rst_usage", 32'(b4.usage_o), 0);
        chk("mid_rst_data",  32'(b4.data_o),  0);

        // Randomized traffic against queue models
        for (int n = 0; n < 300; n++) begin
            b3.push_i  = 1'($urandom_range(0, 1));
            b3.pop_i   = 1'($urandom_range(0, 1));
            b3.data_i  = 8'($urandom);
            b3.flush_i = ($urandom_range(0, 19) == 0);
            b2.push_i  = 1'($urandom_range(0, 1));
            b2.pop_i   = 1'($urandom_range(0, 1));
            b2.data_i  = 8'($urandom);
            b2.flush_i = ($urandom_range(0, 19) == 0);
            #1;
            chk("r3_empty", 32'(b3.empty_o), 32'(q3.size() == 0));
            chk("r3_full",  32'(b3.full_o),  32'(q3.size() == 3));
            chk("r3_usage", 32'(b3.usage_o), 32'(q3.size() % 4));
            if (q3.size() > 0) chk("r3_data", 32'(b3.data_o), 32'(q3[0]));
            ft2 = (q2.size() == 0) && b2.push_i;
            chk("r2_empty", 32'(b2.empty_o), 32'((q2.size() == 0) && !ft2));
            chk("r2_full",  32'(b2.full_o),  32'(q2.size() == 2));
            chk("r2_usage", 32'(b2.usage_o), 32'(q2.size() % 2));
            if (ft2) chk("r2_ft_data", 32'(b2.data_o), 32'(b2.data_i));
            else if (q2.size() > 0) chk("r2_data", 32'(b2.data_o), 32'(q2[0]));
            @(posedge clk);
            if (b3.flush_i) q3.delete();
            else begin
                dp  = b3.pop_i && (q3.size() > 0);
                dpu = b3.push_i && ((q3.size() < 3) || dp);
                if (dp) void'(q3.pop_front());
                if (dpu) q3.push_back(b3.data_i);
            end
            if (b2.flush_i) q2.delete();
            else if (!(ft2 && b2.pop_i)) begin
                dp  = b2.pop_i && (q2.size() > 0);
                dpu = b2.push_i && ((q2.size() < 2) || dp);
                if (dp) void'(q2.pop_front());
                if (dpu) q2.push_back(b2.data_i);
            end
            #1;
        end
        {b3.push_i, b3.pop_i, b3.flush_i} = '0;
        {b2.push_i, b2.pop_i, b2.flush_i} = '0;

        // Pass-through DEPTH=0
        b0.push_i = 1'b1;
        b0.pop_i  = 1'b0;
        b0.data_i = 8'h3C;
        #1;
        chk("pt_data",  32'(b0.data_o),  32'h3C);
        chk("pt_empty", 32'(b0.empty_o), 0);
        chk("pt_full",  32'(b0.full_o),  1);
        chk("pt_usage", 32'(b0.usage_o), 0);
        b0.pop_i = 1'b1;
        #1;
        chk("pt_full_pop", 32'(b0.full_o), 0);
        b0.push_i = 1'b0;
        #1;
        chk("pt_empty_idle", 32'(b0.empty_o), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
